knap_multi_search: RTL
======================

// Module: knap_multi_search
// PURPOSE
//  Sequential search engine for the 0/1 multi-constraint knapsack checkers. Host writes per-item
//  value/weight/volume coefficients, pulses start; block enumerates every item mask 0..2^N_ITEMS-1,
//  one candidate/cycle, applies min-value / max-weight / max-volume test, reports best feasible mask
//  and feasible count; optionally streams every feasible mask out. Drives candidates like the checkers consume them.
// PARAMETERS
//  N_ITEMS     10  number of items (mask width)
//  W           8   coefficient / limit width
//  MIN_VALUE   77  feasibility: total_value >= MIN_VALUE
//  MAX_WEIGHT  60  feasibility: total_weight <= MAX_WEIGHT
//  MAX_VOLUME  60  feasibility: total_volume <= MAX_VOLUME
// PORTS
//  clk         in   1             clock, all logic rising edge
//  rst         in   1             synchronous, active-high reset
//  ld_en       in   1             coefficient write strobe (honoured in IDLE/DONE only)
//  ld_idx      in   clog2(N)      item index; idx >= N_ITEMS ignored
//  ld_value    in   W             item value
//  ld_weight   in   W             item weight
//  ld_volume   in   W             item volume
//  start       in   1             start search (honoured in IDLE/DONE only)
//  busy        out  1             high in RUN
//  done        out  1             1-cycle pulse on RUN->DONE
//  found       out  1             at least one feasible mask seen
//  best_mask   out  N_ITEMS       feasible mask with max total value
//  best_value  out  W+clog2(N)    its total value
//  feas_count  out  N_ITEMS+1     number of feasible masks
//  sol_valid   out  1             stream: feasible mask available (KNAP_STREAM_EN)
//  sol_mask    out  N_ITEMS       stream: mask payload
//  sol_ready   in   1             stream: consumer accepts
// BEHAVIOUR
//  - Reset: state=IDLE; coefficient tables zeroed; all outputs 0. Reset mid-RUN aborts, no done.
//  - Totals computed in W+clog2(N_ITEMS) bits: sum of selected coefficients, no wrap/truncation.
//  - FSM IDLE -start-> RUN; RUN -last mask retired-> DONE; DONE -start-> RUN; DONE holds results.
//  - start: cycle after, busy=1, mask=0; found/best_*/feas_count cleared same edge.
//  - Pipeline: stage0 register mask; stage1 register totals+feasible flag; result update on stage1.
//    First result update 2 cycles after RUN entry; done asserts the cycle after mask 2^N-1 updates.
//  - Best update: feasible && (!found || value > best_value). Strict >: ties keep lowest mask.
//  - ld_en and start while busy ignored, no error. ld_en and start same cycle: write lands first,
//    search uses new coefficient.
//  - Mask counter stops at all-ones; no wrap into a second pass.
// CONFIGURATION
//  KNAP_STREAM_EN defined: each feasible mask presented on sol_valid/sol_mask; sol_valid && !sol_ready
//    stalls whole pipeline (mask counter, stages, results); sol_mask stable while stalled; DONE
//    only after last feasible mask accepted. Non-feasible masks never stall.
//  KNAP_STREAM_EN undefined: no stall logic; sol_valid, sol_mask tied 0; sol_ready ignored;
//    search completes in 2^N_ITEMS+2 cycles after start.
// TESTING
//  1 Reset mid-RUN (after 100 cycles) -> busy=0, done never pulses, found=0, feas_count=0, tables zero.
//  2 All items v=1,w=10,vol=10, MIN_VALUE=0 -> done; found=1, best_value=6,
//    best_mask=0x03F, feas_count=848.
//  3 All-zero tables, default params -> done; found=0, feas_count=0, best_mask=0, no sol_valid.
//  4 Timing, stream off: start at cycle T -> done pulses exactly at T+1026, busy high T+1..T+1025.
//  5 Stream on, table of test 2, sol_ready toggled 1 cycle high / 3 low -> 848 masks accepted,
//    strictly ascending, each popcount<=6, mask stable while stalled, done after last accept.
//  6 start and ld_en while busy -> ignored: results match undisturbed run, tables unchanged.

Source files
------------

// File: rtl/knap_multi_search.sv
// Exhaustive 0/1 multi-constraint knapsack search, one candidate mask per cycle.
// Optional feasible-mask stream with backpressure when KNAP_STREAM_EN is defined.
module knap_multi_search #(
    parameter int N_ITEMS    = 10,
    parameter int W          = 8,
    parameter int MIN_VALUE  = 77,
    parameter int MAX_WEIGHT = 60,
    parameter int MAX_VOLUME = 60,
    localparam int IW = $clog2(N_ITEMS),
    localparam int TW = W + IW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_en,
    input  logic [IW-1:0]      ld_idx,
    input  logic [W-1:0]       ld_value,
    input  logic [W-1:0]       ld_weight,
    input  logic [W-1:0]       ld_volume,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_mask,
    output logic [TW-1:0]      best_value,
    output logic [N_ITEMS:0]   feas_count,
    output logic               sol_valid,
    output logic [N_ITEMS-1:0] sol_mask,
    input  logic               sol_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_n;

    logic [W-1:0] tbl_val [N_ITEMS];
    logic [W-1:0] tbl_wt  [N_ITEMS];
    logic [W-1:0] tbl_vol [N_ITEMS];

    logic [N_ITEMS-1:0] mask_q;
    logic               s0_v;
    logic [N_ITEMS-1:0] s1_mask;
    logic [TW-1:0]      s1_value;
    logic               s1_feas;
    logic               s1_v;
    logic               s1_last;

    logic [TW-1:0] sum_val, sum_wt, sum_vol;
    logic          feas_c;
    logic          stall, idle_ok, go, adv;
    logic          done_q;

    assign idle_ok = (state != RUN);
    assign go      = start && idle_ok;
    assign adv     = (state == RUN) && !stall;
    assign busy    = (state == RUN);
    assign done    = done_q;

`ifdef KNAP_STREAM_EN
    assign sol_valid = (state == RUN) && s1_v && s1_feas;
    assign sol_mask  = sol_valid ? s1_mask : '0;
    assign stall     = sol_valid && !sol_ready;
`else
    logic unused_ready;
    assign unused_ready = sol_ready;
    assign sol_valid    = 1'b0;
    assign sol_mask     = '0;
    assign stall        = 1'b0;
`endif

    // Stage-0 totals: widened sums of the selected coefficients
    always_comb begin
        sum_val = '0;
        sum_wt  = '0;
        sum_vol = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (mask_q[i]) begin
                sum_val = sum_val + {{IW{1'b0}}, tbl_val[i]};
                sum_wt  = sum_wt  + {{IW{1'b0}}, tbl_wt[i]};
                sum_vol = sum_vol + {{IW{1'b0}}, tbl_vol[i]};
            end
        end
        feas_c = (sum_val >= TW'(MIN_VALUE)) &&
                 (sum_wt  <= TW'(MAX_WEIGHT)) &&
                 (sum_vol <= TW'(MAX_VOLUME));
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (!stall && s1_v && s1_last) state_n = DONE;
            DONE:    if (start) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= (state == RUN) && (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                tbl_val[i] <= '0;
                tbl_wt[i]  <= '0;
                tbl_vol[i] <= '0;
            end
        end else if (ld_en && idle_ok && (int'(ld_idx) < N_ITEMS)) begin
            tbl_val[ld_idx] <= ld_value;
            tbl_wt[ld_idx]  <= ld_weight;
            tbl_vol[ld_idx] <= ld_volume;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            s0_v       <= 1'b0;
            s1_mask    <= '0;
            s1_value   <= '0;
            s1_feas    <= 1'b0;
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            found      <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
            feas_count <= '0;
        end else if (go) begin
            mask_q     <= '0;
            s0_v       <= 1'b1;
            s1_v       <= 1'b0;
            found      <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
            feas_count <= '0;
        end else if (adv) begin
            // Counter parks at all-ones so a finished sweep never restarts
            if (s0_v) begin
                if (&mask_q) s0_v <= 1'b0;
                else         mask_q <= mask_q + 1'b1;
            end
            s1_v     <= s0_v;
            s1_mask  <= mask_q;
            s1_value <= sum_val;
            s1_feas  <= feas_c;
            s1_last  <= &mask_q;
            if (s1_v && s1_feas) begin
                feas_count <= feas_count + 1'b1;
                if (!found || (s1_value > best_value)) begin
                    found      <= 1'b1;
                    best_mask  <= s1_mask;
                    best_value <= s1_value;
                end
            end
        end
    end

endmodule
